// File: rtl/cache_types.sv
// Shared cache-coherence types: request-bus message, bus transaction codes
// and the request-bus arbiter state encoding.
package cache_types;

    localparam int SRC_W  = 4;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_GETS = 2'd1,
        BUS_GETM = 2'd2,
        BUS_PUTM = 2'd3
    } bus_tx_t;

    typedef struct packed {
        logic              valid;
        bus_tx_t           bus_tx;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] addr;
    } req_msg_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BCAST  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    // Index width for an agent count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: the first requester at or after last_winner+1 (mod
// NUM_AGENTS) wins; reported both one-hot and as an index.
module rr_priority_picker
    import cache_types::*;
#(
    parameter int NUM_AGENTS = 4,
    localparam int IDX_W     = idx_width(NUM_AGENTS)
) (
    input  logic [NUM_AGENTS-1:0] req,
    input  logic [IDX_W-1:0]      last_winner,
    output logic [NUM_AGENTS-1:0] onehot,
    output logic [IDX_W-1:0]      idx,
    output logic                  any
);

    logic [IDX_W-1:0] cand_s;

    // Rotating search over every agent, nearest-after-last-winner first.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        for (int i = 1; i <= NUM_AGENTS; i++) begin
            cand_s = IDX_W'((int'(last_winner) + i) % NUM_AGENTS);
            if (!any && req[cand_s]) begin
                any            = 1'b1;
                onehot[cand_s] = 1'b1;
                idx            = cand_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Request-bus arbiter: round-robin grant, one-cycle broadcast, lock while any
// agent stalls. Define COH_ARB_TIMEOUT_EN for the LOCKED watchdog/timeout_err.
module coherence_bus_arbiter
    import cache_types::*;
#(
    parameter int NUM_AGENTS     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = idx_width(NUM_AGENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_AGENTS-1:0] agent_req,
    input  req_msg_t [NUM_AGENTS-1:0] agent_tx,
    input  logic [NUM_AGENTS-1:0] agent_busy,
    output logic [NUM_AGENTS-1:0] agent_gnt,
    output req_msg_t              bus_msg,
    output logic [IDX_W-1:0]      bus_owner
`ifdef COH_ARB_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    arb_state_t            state_r;
    logic [IDX_W-1:0]      last_winner_r;
    logic [NUM_AGENTS-1:0] pick_onehot_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_any_s;
    logic                  busy_any_s;
    req_msg_t              win_msg_s;

`ifdef COH_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_r;
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

    rr_priority_picker #(.NUM_AGENTS(NUM_AGENTS)) u_picker (
        .req         (agent_req),
        .last_winner (last_winner_r),
        .onehot      (pick_onehot_s),
        .idx         (pick_idx_s),
        .any         (pick_any_s)
    );

    // Winner's candidate message, stamped with its own index as source.
    always_comb begin
        busy_any_s       = |agent_busy;
        win_msg_s        = agent_tx[pick_idx_s];
        win_msg_s.valid  = 1'b1;
        win_msg_s.source = SRC_W'(pick_idx_s);
    end

    // Arbiter FSM with registered grant, broadcast and owner outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ARB_IDLE;
            last_winner_r <= IDX_W'(NUM_AGENTS - 1);
            bus_msg       <= '0;
            agent_gnt     <= '0;
            bus_owner     <= '0;
`ifdef COH_ARB_TIMEOUT_EN
            timeout_err   <= 1'b0;
            wd_r          <= '0;
`endif
        end else begin
            bus_msg   <= '0;
            agent_gnt <= '0;
            case (state_r)
                ARB_IDLE: begin
                    if (!busy_any_s && pick_any_s) begin
                        state_r       <= ARB_BCAST;
                        bus_msg       <= win_msg_s;
                        agent_gnt     <= pick_onehot_s;
                        bus_owner     <= pick_idx_s;
                        last_winner_r <= pick_idx_s;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_BCAST: begin
                    state_r <= busy_any_s ? ARB_LOCKED : ARB_IDLE;
                end
                ARB_LOCKED: begin
`ifdef COH_ARB_TIMEOUT_EN
                    if (!busy_any_s) begin
                        state_r <= ARB_IDLE;
                        wd_r    <= '0;
                    end else if (wd_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r     <= ARB_IDLE;
                        timeout_err <= 1'b1;
                        wd_r        <= '0;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
`else
                    if (!busy_any_s) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_LOCKED;
                    end
`endif
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Scoreboard bench for coherence_bus_arbiter: directed vectors push expected
// grants (with cycle stamps); a negedge monitor pops and compares.
module tb_coherence_bus_arbiter;
    import cache_types::*;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     agent_req;
    req_msg_t [N-1:0] agent_tx;
    logic [N-1:0]     agent_busy;
    logic [N-1:0]     agent_gnt;
    req_msg_t         bus_msg;
    logic [1:0]       bus_owner;
`ifdef COH_ARB_TIMEOUT_EN
    logic             timeout_err;
`endif

    coherence_bus_arbiter #(.NUM_AGENTS(N), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .agent_req  (agent_req),
        .agent_tx   (agent_tx),
        .agent_busy (agent_busy),
        .agent_gnt  (agent_gnt),
        .bus_msg    (bus_msg),
        .bus_owner  (bus_owner)
`ifdef COH_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [N-1:0] gnt;
        req_msg_t   msg;
        logic [1:0] owner;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int at_cyc, input int agent, input bus_tx_t tx,
                                input logic [31:0] addr);
        exp_t e;
        e.cyc   = at_cyc;
        e.gnt   = 4'b0001 << agent;
        e.msg   = '{valid: 1'b1, bus_tx: tx, source: 4'(agent), addr: addr};
        e.owner = 2'(agent);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    task automatic set_tx(input int agent, input bus_tx_t tx, input logic [31:0] addr);
        agent_tx[agent] = '{valid: 1'b0, bus_tx: tx, source: 4'hF, addr: addr};
    endtask

    // Monitor: every presented grant/broadcast must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus_msg.valid || agent_gnt != 4'b0000) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_grant cyc=%0d got gnt=%b msg=%h required none",
                                 cyc, agent_gnt, bus_msg);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.gnt !== agent_gnt || e.msg !== bus_msg ||
                            e.owner !== bus_owner) begin
                            errors++;
                            $display("FAIL grant got cyc=%0d gnt=%b msg=%h owner=%0d required cyc=%0d gnt=%b msg=%h owner=%0d",
                                     cyc, agent_gnt, bus_msg, bus_owner, e.cyc, e.gnt, e.msg, e.owner);
                        end
                    end
                end else begin
                    checks++;
                    if (bus_msg !== '0) begin
                        errors++;
                        $display("FAIL idle_msg cyc=%0d got=%h required=0", cyc, bus_msg);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int b;
        rst        = 1'b1;
        agent_req  = 4'b0000;
        agent_busy = 4'b0000;
        agent_tx   = '0;
        tick();
        tick();
        chk("reset_gnt", 64'(agent_gnt), 64'h0);
        chk("reset_msg", 64'(bus_msg), 64'h0);
        chk("reset_owner", 64'(bus_owner), 64'h0);
`ifdef COH_ARB_TIMEOUT_EN
        chk("reset_timeout_err", 64'(timeout_err), 64'h0);
`endif
        rst = 1'b0;

        // Single request from agent 2; drops req right after capture.
        set_tx(2, BUS_GETS, 32'h0000_1000);
        agent_req = 4'b0100;
        expect_grant(cyc + 1, 2, BUS_GETS, 32'h0000_1000);
        tick();
        agent_req = 4'b0000;
        tick();
        tick();

        // Fresh reset, then all four request continuously: 0,1,2,3,0 every 2 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_tx(i, (i % 2 == 0) ? BUS_GETM : BUS_GETS, 32'h2000 + 32'(i * 64));
        agent_req = 4'b1111;
        for (int k = 0; k < 5; k++)
            expect_grant(cyc + 1 + 2 * k, k % N, ((k % N) % 2 == 0) ? BUS_GETM : BUS_GETS,
                         32'h2000 + 32'((k % N) * 64));
        repeat (9) tick();
        agent_req = 4'b0000;
        tick();
        tick();

        // GETM from agent 1 then busy for 5 cycles; agent 3 waits.
        set_tx(1, BUS_GETM, 32'h0000_3000);
        set_tx(3, BUS_GETS, 32'h0000_3100);
        agent_req = 4'b1010;
        expect_grant(cyc + 1, 1, BUS_GETM, 32'h0000_3000);
        tick();
        b = cyc;
        agent_busy = 4'b0010;
        agent_req  = 4'b1000;
        expect_grant(b + 7, 3, BUS_GETS, 32'h0000_3100);
        repeat (5) tick();
        agent_busy = 4'b0000;
        tick();
        tick();
        agent_req = 4'b0000;
        tick();
        tick();

        // Busy while idle blocks any grant.
        set_tx(0, BUS_PUTM, 32'h0000_4000);
        agent_busy = 4'b0001;
        agent_req  = 4'b0001;
        repeat (3) tick();
        agent_busy = 4'b0000;
        expect_grant(cyc + 1, 0, BUS_PUTM, 32'h0000_4000);
        tick();
        agent_req = 4'b0000;
        tick();

        // Reset during LOCKED aborts; next grant goes back to agent 0.
        set_tx(2, BUS_GETS, 32'h0000_5000);
        agent_req = 4'b0100;
        expect_grant(cyc + 1, 2, BUS_GETS, 32'h0000_5000);
        tick();
        agent_busy = 4'b1111;
        agent_req  = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_locked_gnt", 64'(agent_gnt), 64'h0);
        chk("rst_locked_msg", 64'(bus_msg), 64'h0);
        agent_busy = 4'b0000;
        for (int i = 0; i < N; i++) set_tx(i, BUS_GETS, 32'h6000 + 32'(i));
        agent_req = 4'b1111;
        expect_grant(cyc + 1, 0, BUS_GETS, 32'h0000_6000);
        tick();
        agent_req = 4'b0000;
        tick();
        tick();

`ifdef COH_ARB_TIMEOUT_EN
        // Busy stuck high: watchdog fires after 8 LOCKED cycles.
        set_tx(1, BUS_GETM, 32'h0000_7000);
        agent_req = 4'b0010;
        expect_grant(cyc + 1, 1, BUS_GETM, 32'h0000_7000);
        tick();
        agent_busy = 4'b1111;
        agent_req  = 4'b0000;
        repeat (8) tick();
        chk("timeout_not_yet", 64'(timeout_err), 64'h0);
        tick();
        chk("timeout_set", 64'(timeout_err), 64'h1);
        tick();
        agent_busy = 4'b0000;
        set_tx(2, BUS_GETS, 32'h0000_7100);
        agent_req = 4'b0100;
        expect_grant(cyc + 1, 2, BUS_GETS, 32'h0000_7100);
        tick();
        agent_req = 4'b0000;
        tick();
        chk("timeout_sticky", 64'(timeout_err), 64'h1);
`endif

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
